// File: rtl/nebula_pkg.sv
// Shared types and constants for the nebula router input side.
package nebula_pkg;

  // Default router radix and flit geometry.
  localparam int NUM_PORTS     = 5;
  localparam int NEBULA_DATA_W = 64;
  localparam int NEBULA_PORT_W = $clog2(NUM_PORTS);

  // One flit as it travels through an input buffer.
  typedef struct packed {
    logic [NEBULA_DATA_W-1:0] data;
    logic [NEBULA_PORT_W-1:0] dest;
    logic                     head;
    logic                     tail;
  } nebula_flit_t;

  // Requestor state: idle (buffer empty), requesting a new packet, locked mid-packet.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOCK = 2'd2
  } nebula_req_state_e;

endpackage

// File: rtl/nebula_credit_counter.sv
// Per-output downstream credit counter: starts full, -1 per sent flit,
// +1 per returned credit, saturates at the maximum and flags the excess return.
module nebula_credit_counter
  import nebula_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             avail,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             overflow_s;

  // Next credit value; a simultaneous return and consume cancel out.
  always_comb begin
    count_nxt_s = count_r;
    overflow_s  = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_r == MAX_CNT) begin
          overflow_s  = 1'b1;
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      2'b01: begin
        if (count_r != {CNT_W{1'b0}}) begin
          count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Credit register, reset to a full allowance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= MAX_CNT;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count    = count_r;
  assign avail    = (count_r != {CNT_W{1'b0}});
  assign overflow = overflow_s;

endmodule

// File: rtl/nebula_input_req_unit.sv
// Router input port requestor: buffers flits, raises a one-hot request toward
// the output arbiters, holds the request for a whole packet (wormhole lock) and
// gates every request on the downstream credits of the targeted output.
module nebula_input_req_unit
  import nebula_pkg::*;
#(
  parameter int NUM_OUTPUTS = NUM_PORTS,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 4,
  parameter int CREDITS     = 4,
  parameter int PORT_W      = $clog2(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [PORT_W-1:0]      in_dest,
  input  logic                   in_head,
  input  logic                   in_tail,
  output logic [NUM_OUTPUTS-1:0] req,
  input  logic [NUM_OUTPUTS-1:0] grant,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [PORT_W-1:0]      out_port,
  output logic                   out_tail,
  input  logic [NUM_OUTPUTS-1:0] credit_return,
  output logic                   err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [NUM_OUTPUTS-1:0] ONE_REQ = NUM_OUTPUTS'(1);

  // Buffer entry at the instance's own widths (same layout as nebula_flit_t).
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [PORT_W-1:0]     dest;
    logic                  head;
    logic                  tail;
  } flit_t;

  flit_t             fifo_mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_nxt_s;
  logic [PW-1:0]     rd_ptr_nxt_s;
  logic              empty_s;
  logic              full_s;
  logic              wr_en_s;
  logic              pop_s;
  logic              nonempty_nxt_s;
  flit_t             head_flit_s;

  nebula_req_state_e state_r;
  logic [PORT_W-1:0] lock_port_r;
  logic [PORT_W-1:0] tgt_port_s;

  logic [NUM_OUTPUTS-1:0] req_s;
  logic [NUM_OUTPUTS-1:0] credit_avail_s;
  logic [NUM_OUTPUTS-1:0] credit_ovf_s;
  logic [NUM_OUTPUTS-1:0] credit_dec_s;
  logic [NUM_OUTPUTS-1:0] credit_zero_s;
  logic [CNT_W-1:0]       credit_cnt_s [NUM_OUTPUTS];

  logic dest_ok_s;
  logic discard_s;
  logic lock_head_err_s;
  logic xfer_s;
  logic spurious_s;
  logic multi_grant_s;
  logic underflow_s;
  logic err_set_s;

  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [PORT_W-1:0]     out_port_r;
  logic                  out_tail_r;
  logic                  err_r;

  // Circular buffer status: the extra pointer bit separates full from empty.
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_flit_s = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign wr_en_s     = in_valid && !full_s;
  assign dest_ok_s   = (int'(head_flit_s.dest) < NUM_OUTPUTS);

  // Request generation: locked packets keep their port, new packets must start with a head flit.
  always_comb begin
    req_s           = {NUM_OUTPUTS{1'b0}};
    tgt_port_s      = head_flit_s.dest;
    discard_s       = 1'b0;
    lock_head_err_s = 1'b0;
    case (state_r)
      LOCK: begin
        tgt_port_s      = lock_port_r;
        lock_head_err_s = !empty_s && head_flit_s.head;
        if (!empty_s && credit_avail_s[lock_port_r]) begin
          req_s = ONE_REQ << lock_port_r;
        end else begin
          req_s = {NUM_OUTPUTS{1'b0}};
        end
      end
      default: begin
        if (empty_s) begin
          req_s = {NUM_OUTPUTS{1'b0}};
        end else if (!head_flit_s.head || !dest_ok_s) begin
          discard_s = 1'b1;
        end else if (credit_avail_s[head_flit_s.dest]) begin
          req_s = ONE_REQ << head_flit_s.dest;
        end else begin
          req_s = {NUM_OUTPUTS{1'b0}};
        end
      end
    endcase
  end

  // Grant decoding: only a grant on the requested bit moves a flit; anything else is an error.
  assign xfer_s        = |(req_s & grant);
  assign spurious_s    = |(grant & ~req_s);
  assign multi_grant_s = ((grant & (grant - ONE_REQ)) != {NUM_OUTPUTS{1'b0}});
  assign credit_dec_s  = req_s & grant;
  assign underflow_s   = |(credit_dec_s & credit_zero_s);
  assign err_set_s     = spurious_s | multi_grant_s | discard_s | lock_head_err_s |
                         (|credit_ovf_s) | underflow_s;

  assign pop_s          = xfer_s || discard_s;
  assign wr_ptr_nxt_s   = wr_en_s ? (wr_ptr_r + {{(PW-1){1'b0}}, 1'b1}) : wr_ptr_r;
  assign rd_ptr_nxt_s   = pop_s   ? (rd_ptr_r + {{(PW-1){1'b0}}, 1'b1}) : rd_ptr_r;
  assign nonempty_nxt_s = (wr_ptr_nxt_s != rd_ptr_nxt_s);

  // One credit counter per output arbiter.
  for (genvar p = 0; p < NUM_OUTPUTS; p++) begin : g_credit
    nebula_credit_counter #(
      .CREDITS (CREDITS)
    ) u_credit (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (credit_return[p]),
      .dec      (credit_dec_s[p]),
      .count    (credit_cnt_s[p]),
      .avail    (credit_avail_s[p]),
      .overflow (credit_ovf_s[p])
    );
    assign credit_zero_s[p] = (credit_cnt_s[p] == {CNT_W{1'b0}});
  end

  // Input buffer storage and pointers; reset flushes any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= {$bits(flit_t){1'b0}};
      end
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (wr_en_s) begin
        fifo_mem_r[wr_ptr_r[AW-1:0]] <= {in_data, in_dest, in_head, in_tail};
      end
    end
  end

  // Requestor FSM: a head-only transfer locks the port until the tail transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lock_port_r <= {PORT_W{1'b0}};
    end else begin
      case (state_r)
        LOCK: begin
          if (xfer_s && head_flit_s.tail) begin
            state_r <= nonempty_nxt_s ? REQ : IDLE;
          end else begin
            state_r <= LOCK;
          end
        end
        default: begin
          if (xfer_s && !head_flit_s.tail) begin
            state_r     <= LOCK;
            lock_port_r <= tgt_port_s;
          end else begin
            state_r <= nonempty_nxt_s ? REQ : IDLE;
          end
        end
      endcase
    end
  end

  // Crossbar output register: one-cycle valid pulse per transferred flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_port_r  <= {PORT_W{1'b0}};
      out_tail_r  <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= head_flit_s.data;
      out_port_r  <= tgt_port_s;
      out_tail_r  <= head_flit_s.tail;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign in_ready  = !full_s;
  assign req       = req_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_port  = out_port_r;
  assign out_tail  = out_tail_r;
  assign err       = err_r;

endmodule

// File: tb/tb_nebula_input_req_unit.sv
// Self-checking bench for nebula_input_req_unit (5 outputs, depth 4, 4 credits).
module tb_nebula_input_req_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'd0;
  logic [2:0]  in_dest = 3'd0;
  logic        in_head = 1'b0;
  logic        in_tail = 1'b0;
  logic [4:0]  req;
  logic [4:0]  grant;
  logic        out_valid;
  logic [63:0] out_data;
  logic [2:0]  out_port;
  logic        out_tail;
  logic [4:0]  credit_return = 5'd0;
  logic        err;

  logic        auto_grant = 1'b0;
  logic [4:0]  grant_man = 5'd0;

  int tests_run = 0;
  int fails = 0;

  logic [67:0] exp_q[$];
  logic [67:0] obs_q[$];

  // The bench plays the arbiter: either grant whatever is requested or drive a fixed pattern.
  assign grant = auto_grant ? req : grant_man;

  nebula_input_req_unit #(
    .NUM_OUTPUTS (5),
    .DATA_WIDTH  (64),
    .DEPTH       (4),
    .CREDITS     (4),
    .PORT_W      (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_dest       (in_dest),
    .in_head       (in_head),
    .in_tail       (in_tail),
    .req           (req),
    .grant         (grant),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_port      (out_port),
    .out_tail      (out_tail),
    .credit_return (credit_return),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Capture every flit leaving toward the crossbar.
  always @(negedge clk) begin
    if (rst_n && out_valid) obs_q.push_back({out_data, out_port, out_tail});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [63:0] d, input logic [2:0] dst, input logic h, input logic t);
    int w = 0;
    in_valid = 1'b1; in_data = d; in_dest = dst; in_head = h; in_tail = t;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      tests_run++; fails++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; in_valid = 1'b0; auto_grant = 1'b0; grant_man = 5'd0; credit_return = 5'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic pulse_return(input logic [4:0] mask, input int n);
    credit_return = mask;
    repeat (n) tick();
    credit_return = 5'd0;
  endtask

  task automatic test_reset;
    logic [67:0] outs;
    outs = {out_data, out_port, out_tail};
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL reset_req: got %b required 00000", req); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    tests_run++; if (outs !== 68'd0) begin fails++; $display("FAIL reset_out_regs: got %h required 0", outs); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", err); end
  endtask

  task automatic test_single_flit;
    logic [67:0] e, o;
    push_flit(64'hA5A5_0000_0000_0001, 3'd2, 1'b1, 1'b1);
    exp_q.push_back({64'hA5A5_0000_0000_0001, 3'd2, 1'b1});
    tests_run++; if (req !== 5'b00100) begin fails++; $display("FAIL single_req_t1: got %b required 00100", req); end
    grant_man = 5'b00100;
    tick();
    grant_man = 5'd0;
    tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid_t2: got %b required 1", out_valid); end
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL single_req_after: got %b required 00000", req); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_pulse: got %b required 0", out_valid); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL single_err: got %b required 0", err); end
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL single_flit: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_return(5'b00100, 1);
  endtask

  task automatic test_wormhole;
    logic [67:0] e, o;
    logic [4:0] wh_req [4];
    wh_req = '{5'b00010, 5'b00010, 5'b00010, 5'b01000};
    push_flit(64'h1111, 3'd1, 1'b1, 1'b0);
    push_flit(64'h2222, 3'd4, 1'b0, 1'b0);
    push_flit(64'h3333, 3'd0, 1'b0, 1'b1);
    push_flit(64'h4444, 3'd3, 1'b1, 1'b1);
    exp_q.push_back({64'h1111, 3'd1, 1'b0});
    exp_q.push_back({64'h2222, 3'd1, 1'b0});
    exp_q.push_back({64'h3333, 3'd1, 1'b1});
    exp_q.push_back({64'h4444, 3'd3, 1'b1});
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL wh_full: in_ready got %b required 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (req !== wh_req[i]) begin fails++; $display("FAIL wh_req_%0d: got %b required %b", i, req, wh_req[i]); end
      grant_man = wh_req[i];
      tick();
      grant_man = 5'd0;
    end
    tick();
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL wh_req_end: got %b required 00000", req); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL wh_err: got %b required 0", err); end
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL wh_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL wh_flit: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_return(5'b01010, 1);
    pulse_return(5'b00010, 2);
  endtask

  task automatic test_credit_exhaust;
    logic [67:0] e, o;
    auto_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_flit(64'hC000 + 64'(i), 3'd0, 1'b1, 1'b1);
      if (i < 4) exp_q.push_back({64'hC000 + 64'(i), 3'd0, 1'b1});
    end
    repeat (4) tick();
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL cr_req_gated: got %b required 00000", req); end
    exp_q.push_back({64'hC004, 3'd0, 1'b1});
    pulse_return(5'b00001, 1);
    repeat (3) tick();
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL cr_req_gated2: got %b required 00000", req); end
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL cr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL cr_flit: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_return(5'b00001, 1);
    repeat (3) tick();
    pulse_return(5'b00001, 4);
    obs_q.delete();
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL cr_err: got %b required 0", err); end
    auto_grant = 1'b0;
  endtask

  task automatic test_simul_credit;
    logic [67:0] e, o;
    auto_grant = 1'b1;
    push_flit(64'h5555, 3'd4, 1'b1, 1'b1);
    exp_q.push_back({64'h5555, 3'd4, 1'b1});
    pulse_return(5'b10000, 1);
    tick();
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL sim_err_none: got %b required 0", err); end
    pulse_return(5'b10000, 1);
    tick();
    tests_run++; if (err !== 1'b1) begin fails++; $display("FAIL sim_err_ovf: got %b required 1", err); end
    for (int i = 0; i < 5; i++) begin
      push_flit(64'h5100 + 64'(i), 3'd4, 1'b1, 1'b1);
      if (i < 4) exp_q.push_back({64'h5100 + 64'(i), 3'd4, 1'b1});
    end
    repeat (4) tick();
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL sim_req_gated: got %b required 00000", req); end
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL sim_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL sim_flit: got %h required %h", o, e); end
    end
    apply_reset();
  endtask

  task automatic test_spurious_grant;
    logic [67:0] e, o;
    push_flit(64'h6666, 3'd0, 1'b1, 1'b1);
    tests_run++; if (req !== 5'b00001) begin fails++; $display("FAIL spur_req: got %b required 00001", req); end
    grant_man = 5'b01000;
    tick();
    grant_man = 5'd0;
    tests_run++; if (err !== 1'b1) begin fails++; $display("FAIL spur_err: got %b required 1", err); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL spur_no_out: got %b required 0", out_valid); end
    tests_run++; if (req !== 5'b00001) begin fails++; $display("FAIL spur_no_pop: got %b required 00001", req); end
    grant_man = 5'b00001;
    tick();
    grant_man = 5'd0;
    exp_q.push_back({64'h6666, 3'd0, 1'b1});
    tick();
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL spur_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL spur_flit: got %h required %h", o, e); end
    end
    apply_reset();
  endtask

  task automatic test_body_discard;
    logic [67:0] e, o;
    auto_grant = 1'b1;
    push_flit(64'h7777, 3'd2, 1'b0, 1'b1);
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL disc_req: got %b required 00000", req); end
    tick();
    tests_run++; if (err !== 1'b1) begin fails++; $display("FAIL disc_err: got %b required 1", err); end
    push_flit(64'h7878, 3'd2, 1'b1, 1'b1);
    exp_q.push_back({64'h7878, 3'd2, 1'b1});
    repeat (3) tick();
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL disc_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL disc_flit: got %h required %h", o, e); end
    end
    apply_reset();
  endtask

  task automatic test_full_and_reset;
    logic [67:0] e, o;
    auto_grant = 1'b1;
    push_flit(64'h8888, 3'd2, 1'b1, 1'b0);
    exp_q.push_back({64'h8888, 3'd2, 1'b0});
    tick();
    auto_grant = 1'b0;
    for (int i = 0; i < 4; i++) push_flit(64'h8900 + 64'(i), 3'd0, 1'b0, 1'b0);
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
    tests_run++; if (req !== 5'b00100) begin fails++; $display("FAIL full_lock_req: got %b required 00100", req); end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL rst_req: got %b required 00000", req); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL rst_flit: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    auto_grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_flit(64'h9900 + 64'(i), 3'd2, 1'b1, 1'b1);
      if (i < 4) exp_q.push_back({64'h9900 + 64'(i), 3'd2, 1'b1});
    end
    repeat (4) tick();
    tests_run++; if (req !== 5'b00000) begin fails++; $display("FAIL rst_credit_gate: got %b required 00000", req); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b required 0", err); end
    tests_run++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_credit_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++; if (o !== e) begin fails++; $display("FAIL rst_credit_flit: got %h required %h", o, e); end
    end
    apply_reset();
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single_flit();
    test_wormhole();
    test_credit_exhaust();
    test_simul_credit();
    test_spurious_grant();
    test_body_discard();
    test_full_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
